icache_ifill_responder: RTL

- Responder end of the instruction-cache refill (IFILL) interface.
- Accepts one line-refill request at a time from the L1 I-cache controller and issues a line-aligned read to the memory side.
- Assembles MEM_DATA_W-bit beats into a SET_WIDHT-bit line and returns it on the IFILL response bundle.
- Also forwards external invalidations to the I-cache on the same bundle and re-fetches the line if an invalidation hits the in-flight refill.

---
 rtl/sargantana_icache_pkg.sv | 42 ++++
 rtl/icache_ifill_inv_buf.sv | 49 ++++
 rtl/icache_ifill_responder.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/sargantana_icache_pkg.sv
// Shared I-cache types and constants, including the IFILL responder state
// encoding and its default memory beat geometry.
package sargantana_icache_pkg;

  localparam int unsigned PHY_ADDR_SIZE       = 40;
  localparam int unsigned ICACHE_N_WAY        = 4;
  localparam int unsigned ICACHE_WAY_WIDTH    = 2;
  localparam int unsigned ICACHE_OFFSET_WIDTH = 5;
  localparam int unsigned ICACHE_INDEX_WIDTH  = 14;
  localparam int unsigned SET_WIDHT           = 256;

  localparam int unsigned IFILL_MEM_DATA_W = 64;
  localparam int unsigned IFILL_NBEATS     = SET_WIDHT / IFILL_MEM_DATA_W;
  localparam int unsigned IFILL_BEAT_W     = 2;

  typedef struct packed {
    logic                          valid;
    logic [ICACHE_INDEX_WIDTH-1:0] paddr;
  } inv_t;

  typedef struct packed {
    logic                        valid;
    logic [ICACHE_WAY_WIDTH-1:0] way;
    logic [PHY_ADDR_SIZE-1:0]    paddr;
  } ifill_req_o_t;

  typedef struct packed {
    logic                    valid;
    logic                    ack;
    logic [SET_WIDHT-1:0]    data;
    logic [IFILL_BEAT_W-1:0] beat;
    inv_t                    inv;
  } ifill_resp_i_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL,
    RESP
  } ifill_state_t;

endpackage

// File: rtl/icache_ifill_inv_buf.sv
// One-entry invalidation buffer: presents each accepted invalidation for one
// cycle, holding it back while the refill response occupies the bundle.
module icache_ifill_inv_buf
  import sargantana_icache_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          inv_valid_i,
  input  logic [ICACHE_INDEX_WIDTH-1:0] inv_paddr_i,
  input  logic                          defer_i,
  output logic                          inv_ready_o,
  output logic                          accept_o,
  output inv_t                          inv_o
);

  logic                          full_q,  full_d;
  logic [ICACHE_INDEX_WIDTH-1:0] paddr_q, paddr_d;
  logic                          emit;

  assign emit        = full_q && !defer_i;
  // Emission frees the slot in the same cycle, so back-to-back requests flow.
  assign inv_ready_o = !full_q || emit;
  assign accept_o    = inv_valid_i && inv_ready_o;

  assign inv_o.valid = emit;
  assign inv_o.paddr = emit ? paddr_q : '0;

  always_comb begin
    full_d  = full_q;
    paddr_d = paddr_q;
    if (accept_o) begin
      full_d  = 1'b1;
      paddr_d = inv_paddr_i;
    end else if (emit) begin
      full_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      full_q  <= 1'b0;
      paddr_q <= '0;
    end else begin
      full_q  <= full_d;
      paddr_q <= paddr_d;
    end
  end

endmodule

// File: rtl/icache_ifill_responder.sv
// Responder end of the I-cache refill interface: fetches one line from memory
// per request, assembles beats, and forwards external invalidations.
module icache_ifill_responder
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned MEM_DATA_W = IFILL_MEM_DATA_W
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  ifill_req_o_t                  ifill_req_i,
  output ifill_resp_i_t                 ifill_resp_o,
  output logic                          mem_req_valid_o,
  input  logic                          mem_req_ready_i,
  output logic [PHY_ADDR_SIZE-1:0]      mem_req_addr_o,
  input  logic                          mem_rsp_valid_i,
  input  logic [MEM_DATA_W-1:0]         mem_rsp_data_i,
  input  logic                          inv_valid_i,
  input  logic [ICACHE_INDEX_WIDTH-1:0] inv_paddr_i,
  output logic                          inv_ready_o
);

  localparam int unsigned NBEATS = SET_WIDHT / MEM_DATA_W;
  localparam int unsigned CNT_W  = 2;

  if ((MEM_DATA_W != 64 && MEM_DATA_W != 128 && MEM_DATA_W != 256) ||
      (SET_WIDHT % MEM_DATA_W != 0) || (NBEATS == 0) || (NBEATS > 4)) begin : g_bad_param
    $error("icache_ifill_responder: unsupported MEM_DATA_W %0d", MEM_DATA_W);
  end

  ifill_state_t                  state_q;
  logic [PHY_ADDR_SIZE-1:0]      paddr_q;
  logic [ICACHE_WAY_WIDTH-1:0]   way_q;
  logic [CNT_W-1:0]              cnt_q;
  logic                          poison_q;
  logic [SET_WIDHT-1:0]          line_q, line_d;
  logic                          mem_req_valid_q;
  logic                          resp_valid_q;
  logic                          resp_ack_q;
  logic [SET_WIDHT-1:0]          resp_data_q;
  logic [IFILL_BEAT_W-1:0]       resp_beat_q;

  logic                          inv_accept;
  logic                          inv_hit;
  logic                          last_beat;
  inv_t                          inv_out;

  icache_ifill_inv_buf u_inv_buf (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .inv_valid_i (inv_valid_i),
    .inv_paddr_i (inv_paddr_i),
    .defer_i     (state_q == RESP),
    .inv_ready_o (inv_ready_o),
    .accept_o    (inv_accept),
    .inv_o       (inv_out)
  );

  // Only the set index matters for a hit; offset bits name bytes inside the line.
  assign inv_hit = inv_accept && (state_q == REQ || state_q == FILL) &&
                   (inv_paddr_i[ICACHE_INDEX_WIDTH-1:ICACHE_OFFSET_WIDTH] ==
                    paddr_q[ICACHE_INDEX_WIDTH-1:ICACHE_OFFSET_WIDTH]);

  assign last_beat = (cnt_q == CNT_W'(NBEATS - 1));

  always_comb begin
    line_d = line_q;
    if (state_q == FILL && mem_rsp_valid_i) begin
      for (int unsigned b = 0; b < NBEATS; b++) begin
        if (cnt_q == CNT_W'(b)) begin
          line_d[b*MEM_DATA_W +: MEM_DATA_W] = mem_rsp_data_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q         <= IDLE;
      paddr_q         <= '0;
      way_q           <= '0;
      cnt_q           <= '0;
      poison_q        <= 1'b0;
      line_q          <= '0;
      mem_req_valid_q <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_ack_q      <= 1'b0;
      resp_data_q     <= '0;
      resp_beat_q     <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_ack_q   <= 1'b0;
      line_q       <= line_d;
      unique case (state_q)
        IDLE: begin
          if (ifill_req_i.valid) begin
            paddr_q         <= {ifill_req_i.paddr[PHY_ADDR_SIZE-1:ICACHE_OFFSET_WIDTH],
                                {ICACHE_OFFSET_WIDTH{1'b0}}};
            way_q           <= ifill_req_i.way;
            poison_q        <= 1'b0;
            resp_ack_q      <= 1'b1;
            mem_req_valid_q <= 1'b1;
            state_q         <= REQ;
          end
        end
        REQ: begin
          if (inv_hit) poison_q <= 1'b1;
          if (mem_req_ready_i) begin
            mem_req_valid_q <= 1'b0;
            cnt_q           <= '0;
            state_q         <= FILL;
          end
        end
        FILL: begin
          if (inv_hit) poison_q <= 1'b1;
          if (mem_rsp_valid_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_beat) begin
              // A hit landing on the final beat still invalidates this line.
              if (poison_q || inv_hit) begin
                poison_q        <= 1'b0;
                mem_req_valid_q <= 1'b1;
                cnt_q           <= '0;
                state_q         <= REQ;
              end else begin
                resp_valid_q <= 1'b1;
                resp_data_q  <= line_d;
                resp_beat_q  <= IFILL_BEAT_W'(NBEATS - 1);
                state_q      <= RESP;
              end
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_req_valid_o    = mem_req_valid_q;
  assign mem_req_addr_o     = paddr_q;
  assign ifill_resp_o.valid = resp_valid_q;
  assign ifill_resp_o.ack   = resp_ack_q;
  assign ifill_resp_o.data  = resp_data_q;
  assign ifill_resp_o.beat  = resp_beat_q;
  assign ifill_resp_o.inv   = inv_out;

  logic unused_ok;
  assign unused_ok = ^{way_q, ifill_req_i.paddr[ICACHE_OFFSET_WIDTH-1:0]};

  a_no_inv_resp_overlap : assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(ifill_resp_o.valid && ifill_resp_o.inv.valid));

  a_req_stable : assert property (@(posedge clk_i) disable iff (!rstn_i)
    (mem_req_valid_o && !mem_req_ready_i) |=> (mem_req_valid_o && $stable(mem_req_addr_o)));

endmodule
